ins_fp_arbiter: RTL and testbench



---
 rtl/ins_fp_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ins_fp_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fp_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP core among N requesters.
// Issued tags ride a shift register whose head lines up with the core's result strobe.
module ins_fp_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned TW        = 2,
  parameter int unsigned LAT       = 8,
  parameter bit          PIPELINED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [32*N-1:0]   opa,
  input  logic [32*N-1:0]   opb,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      res_valid,
  output logic [31:0]       res_data,
  output logic [31:0]       fp_a,
  output logic [31:0]       fp_b,
  output logic              fp_nd,
  input  logic [31:0]       fp_result,
  input  logic              fp_rdy,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DW    = 32;
  // fp_nd is seen by the core one cycle after issue, so the head sits LAT+1 stages deep
  localparam int unsigned DEPTH = LAT + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     ptr_q, ptr_d;
  logic [DW-1:0]     fp_a_q, fp_a_d;
  logic [DW-1:0]     fp_b_q, fp_b_d;
  logic              fp_nd_q, fp_nd_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic [DEPTH-1:0]  tv_q, tv_d;
  logic [TW-1:0]     tt_q [DEPTH];
  logic [TW-1:0]     tt_d [DEPTH];
  logic [N-1:0]      res_valid_q, res_valid_d;
  logic [DW-1:0]     res_data_q, res_data_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [DW-1:0]     opa_w [N];
  logic [DW-1:0]     opb_w [N];
  logic              can_issue_c;
  logic              found_c;
  logic [TW-1:0]     win_c;
  logic [TW-1:0]     idx_c;
  logic              head_v_c;
  logic [TW-1:0]     head_t_c;

  for (genvar g = 0; g < N; g++) begin : g_split
    assign opa_w[g] = opa[g*DW +: DW];
    assign opb_w[g] = opb[g*DW +: DW];
  end

  assign can_issue_c = PIPELINED ? 1'b1 : (state_q == S_IDLE);
  assign head_v_c    = tv_q[DEPTH-1];
  assign head_t_c    = tt_q[DEPTH-1];

  // Round-robin scan starting just after the last winner
  always_comb begin
    gnt     = '0;
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx_c = TW'((32'(ptr_q) + k) % N);
      if (!found_c && can_issue_c && req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
    if (found_c) begin
      gnt[win_c] = 1'b1;
    end
  end

  // Issue, tag pipeline, result return and error next-state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    fp_a_d      = fp_a_q;
    fp_b_d      = fp_b_q;
    fp_nd_d     = 1'b0;
    tag_d       = tag_q;
    res_valid_d = '0;
    res_data_d  = res_data_q;
    err_d       = err_q;

    if (found_c) begin
      fp_a_d  = opa_w[win_c];
      fp_b_d  = opb_w[win_c];
      fp_nd_d = 1'b1;
      tag_d   = win_c;
      ptr_d   = win_c;
    end

    tv_d     = {tv_q[DEPTH-2:0], fp_nd_q};
    tt_d[0]  = tag_q;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      tt_d[i] = tt_q[i-1];
    end

    if (fp_rdy && head_v_c) begin
      res_valid_d[head_t_c] = 1'b1;
      res_data_d            = fp_result;
    end else if (fp_rdy != head_v_c) begin
      err_d = 1'b1;
    end

    if (!PIPELINED) begin
      case (state_q)
        S_IDLE:  if (found_c) state_d = S_WAIT;
        S_WAIT:  if (fp_rdy)  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (|tv_d) | fp_nd_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= TW'(N - 1);
      fp_a_q      <= '0;
      fp_b_q      <= '0;
      fp_nd_q     <= 1'b0;
      tag_q       <= '0;
      tv_q        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tt_q[i] <= '0;
      end
      res_valid_q <= '0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fp_a_q      <= fp_a_d;
      fp_b_q      <= fp_b_d;
      fp_nd_q     <= fp_nd_d;
      tag_q       <= tag_d;
      tv_q        <= tv_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tt_q[i] <= tt_d[i];
      end
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign fp_a      = fp_a_q;
  assign fp_b      = fp_b_q;
  assign fp_nd     = fp_nd_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ins_fp_arbiter.sv
// Bench for ins_fp_arbiter: random and directed traffic against a queue-based reference model.
module tb_ins_fp_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TW  = 2;
  localparam int unsigned LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Pipelined DUT
  logic [N-1:0]    req;
  logic [31:0]     opa_v [N];
  logic [31:0]     opb_v [N];
  logic [32*N-1:0] opa, opb;
  logic [N-1:0]    gnt, res_valid;
  logic [31:0]     res_data, fp_a, fp_b, fp_result;
  logic            fp_nd, fp_rdy, busy, err;
  logic            inj_rdy;

  // Non-pipelined DUT
  logic [N-1:0]    req_np;
  logic [31:0]     opa_np_v [N];
  logic [31:0]     opb_np_v [N];
  logic [32*N-1:0] opa_np, opb_np;
  logic [N-1:0]    gnt_np, res_valid_np;
  logic [31:0]     res_data_np, fp_a_np, fp_b_np, fp_result_np;
  logic            fp_nd_np, fp_rdy_np, busy_np, err_np;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign opa[32*g +: 32]    = opa_v[g];
    assign opb[32*g +: 32]    = opb_v[g];
    assign opa_np[32*g +: 32] = opa_np_v[g];
    assign opb_np[32*g +: 32] = opb_np_v[g];
  end

  ins_fp_arbiter #(.N(N), .TW(TW), .LAT(LAT), .PIPELINED(1'b1)) u_dut (
    .clk(clk), .rst(rst_n), .req(req), .opa(opa), .opb(opb), .gnt(gnt),
    .res_valid(res_valid), .res_data(res_data), .fp_a(fp_a), .fp_b(fp_b),
    .fp_nd(fp_nd), .fp_result(fp_result), .fp_rdy(fp_rdy), .busy(busy), .err(err)
  );

  ins_fp_arbiter #(.N(N), .TW(TW), .LAT(LAT), .PIPELINED(1'b0)) u_dut_np (
    .clk(clk), .rst(rst_n), .req(req_np), .opa(opa_np), .opb(opb_np), .gnt(gnt_np),
    .res_valid(res_valid_np), .res_data(res_data_np), .fp_a(fp_a_np), .fp_b(fp_b_np),
    .fp_nd(fp_nd_np), .fp_result(fp_result_np), .fp_rdy(fp_rdy_np), .busy(busy_np), .err(err_np)
  );

  // Single-precision multiply via double arithmetic (normal operands only)
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) * sp2r(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(144, 110)), 23'($urandom)};
  endfunction

  // Fixed-latency core models sharing the arbiter reset
  logic [LAT-1:0] cv, cv_np;
  logic [31:0]    cd [LAT];
  logic [31:0]    cd_np [LAT];
  logic           core_rdy, core_rdy_np;
  logic [31:0]    core_res, core_res_np;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv <= '0; core_rdy <= 1'b0; core_res <= '0;
      cv_np <= '0; core_rdy_np <= 1'b0; core_res_np <= '0;
    end else begin
      cv       <= {cv[LAT-2:0], fp_nd};
      cd[0]    <= fpmul(fp_a, fp_b);
      core_rdy <= cv[LAT-1];
      core_res <= cd[LAT-1];
      cv_np       <= {cv_np[LAT-2:0], fp_nd_np};
      cd_np[0]    <= fpmul(fp_a_np, fp_b_np);
      core_rdy_np <= cv_np[LAT-1];
      core_res_np <= cd_np[LAT-1];
      for (int i = 1; i < LAT; i++) begin
        cd[i]    <= cd[i-1];
        cd_np[i] <= cd_np[i-1];
      end
    end
  end

  assign fp_rdy       = core_rdy | inj_rdy;
  assign fp_result    = core_res;
  assign fp_rdy_np    = core_rdy_np;
  assign fp_result_np = core_res_np;

  // Reference model state
  typedef struct {
    int          g;
    int          who;
    logic [31:0] a;
    logic [31:0] res;
  } op_t;

  op_t          ops[$];
  int           m_ptr;
  logic         m_err;
  int           cyc;
  int           checks;
  int           failures;
  logic [N-1:0] cont;
  bit           rnd;
  int           waitc [N];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  task automatic check_cycle(output int w);
    logic [N-1:0] eg;
    logic [N-1:0] er;
    op_t          o;
    bit           ev;
    bit           nd;
    bit           bz;
    logic [31:0]  nda;
    w = -1;
    for (int k = 1; k <= int'(N); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(N);
      if (w < 0 && req[idx]) w = idx;
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    ev = 1'b0;
    if (ops.size() > 0 && ops[0].g + int'(LAT) + 2 == cyc) begin
      o  = ops.pop_front();
      ev = 1'b1;
    end
    er = '0;
    if (ev) er[o.who] = 1'b1;
    chk("res_valid", 32'(res_valid), 32'(er));
    if (ev) chk("res_data", res_data, o.res);
    nd = 1'b0; bz = 1'b0; nda = '0;
    foreach (ops[i]) begin
      if (ops[i].g <= cyc) bz = 1'b1;
      if (ops[i].g == cyc) begin nd = 1'b1; nda = ops[i].a; end
    end
    chk("fp_nd", 32'(fp_nd), 32'(nd));
    if (nd) chk("fp_a", fp_a, nda);
    chk("busy", 32'(busy), 32'(bz));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic update_stim(input int w);
    for (int i = 0; i < int'(N); i++) begin
      if (i == w) begin
        chk("starve", 32'(waitc[i] < int'(N)), 32'd1);
        waitc[i] = 0;
        if (cont[i] || (rnd && $urandom_range(1) == 1)) begin
          opa_v[i] = rand_fp();
          opb_v[i] = rand_fp();
        end else begin
          req[i] = 1'b0;
        end
      end else if (req[i]) begin
        waitc[i]++;
      end else if (rnd && $urandom_range(2) == 0) begin
        req[i]   = 1'b1;
        opa_v[i] = rand_fp();
        opb_v[i] = rand_fp();
        waitc[i] = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      int w;
      @(negedge clk);
      check_cycle(w);
      @(posedge clk);
      cyc++;
      if (inj_rdy) m_err = 1'b1;
      if (w >= 0) begin
        m_ptr = w;
        ops.push_back('{g: cyc, who: w, a: opa_v[w], res: fpmul(opa_v[w], opb_v[w])});
      end
      #1;
      inj_rdy = 1'b0;
      update_stim(w);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_gnt"}, 32'(gnt), 32'd0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({pfx, "_res_data"}, res_data, 32'd0);
    chk({pfx, "_fp_a"}, fp_a, 32'd0);
    chk({pfx, "_fp_b"}, fp_b, 32'd0);
    chk({pfx, "_fp_nd"}, 32'(fp_nd), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic set_oneshot(input logic [N-1:0] r);
    for (int i = 0; i < int'(N); i++) begin
      if (r[i]) begin
        req[i]   = 1'b1;
        opa_v[i] = rand_fp();
        opb_v[i] = rand_fp();
        waitc[i] = 0;
      end
    end
  endtask

  // Non-pipelined run: one op outstanding, next grant only after its result edge
  task automatic run_np(input int n);
    int np_ptr, np_g, np_who;
    np_ptr = int'(N) - 1;
    np_g   = -100;
    np_who = 0;
    for (int c = 0; c < n; c++) begin
      int           w;
      logic [N-1:0] eg;
      logic [N-1:0] er;
      bit           ev;
      @(negedge clk);
      w = -1;
      if (cyc >= np_g + int'(LAT) + 2) begin
        for (int k = 1; k <= int'(N); k++) begin
          int idx;
          idx = (np_ptr + k) % int'(N);
          if (w < 0 && req_np[idx]) w = idx;
        end
      end
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("np_gnt", 32'(gnt_np), 32'(eg));
      ev = (cyc == np_g + int'(LAT) + 2);
      er = '0;
      if (ev) er[np_who] = 1'b1;
      chk("np_res_valid", 32'(res_valid_np), 32'(er));
      if (ev) chk("np_res_data", res_data_np, fpmul(opa_np_v[np_who], opb_np_v[np_who]));
      chk("np_busy", 32'(busy_np), 32'(cyc >= np_g && cyc <= np_g + int'(LAT) + 1));
      @(posedge clk);
      cyc++;
      if (w >= 0) begin
        np_ptr = w;
        np_who = w;
        np_g   = cyc;
      end
      #1;
    end
    chk("np_err", 32'(err_np), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    req = '0; req_np = '0; inj_rdy = 1'b0; rnd = 1'b0; cont = '0;
    m_ptr = int'(N) - 1; m_err = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      opa_v[i] = '0; opb_v[i] = '0; waitc[i] = 0;
      opa_np_v[i] = rand_fp(); opb_np_v[i] = rand_fp();
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request, 1.0 * 2.0
    opa_v[2] = 32'h3F80_0000;
    opb_v[2] = 32'h4000_0000;
    req[2]   = 1'b1;
    run(int'(LAT) + 6);

    // All four requesting continuously
    cont = '1;
    set_oneshot('1);
    run(20);
    cont = '0;
    req  = '0;
    run(int'(LAT) + 4);

    // Wrap: park pointer on 1, then 3 and 0, then alternate 1/3
    set_oneshot(4'b0010);
    run(2);
    set_oneshot(4'b1001);
    run(3);
    cont = 4'b1010;
    set_oneshot(4'b1010);
    run(12);
    cont = '0;
    req  = '0;
    run(int'(LAT) + 4);

    // Random traffic
    rnd = 1'b1;
    run(400);
    rnd = 1'b0;
    req = '0;
    run(int'(LAT) + 4);

    // Stray fp_rdy with empty pipeline, then a legal op
    inj_rdy = 1'b1;
    run(2);
    set_oneshot(4'b0010);
    run(int'(LAT) + 6);

    // Reset with three ops in flight
    cont = '1;
    set_oneshot('1);
    run(3);
    cont = '0;
    req  = '0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    ops.delete();
    m_ptr = int'(N) - 1;
    m_err = 1'b0;
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
    run(int'(LAT) + 4);
    set_oneshot('1);
    run(int'(LAT) + 8);

    // Non-pipelined variant, everyone requesting
    req_np = '1;
    run_np(4 * (int'(LAT) + 3) + 6);
    req_np = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
